ntsc_pix_fetch: RTL and testbench
=================================

NTSC_PIX_FETCH -- requirements
Module: ntsc_pix_fetch

Interface
REQ-001 SHALL have port clock, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port pixPosX, input, 10 bits: current pixel column from the NTSC encoder, 0..639 while active, 0 otherwise.
REQ-004 SHALL have port pixPosY, input, 10 bits: current row from the NTSC encoder, which wraps modulo 1024.
REQ-005 SHALL have port baseAddr, input, 24 bits: framebuffer word address of row 0, sampled when each fetch starts.
REQ-006 SHALL have port memReq, output, 1 bit: memory read request.
REQ-007 SHALL have port memAddr, output, 24 bits: 32-bit-word read address.
REQ-008 SHALL have port memAck, input, 1 bit: one-cycle read completion; memData is valid in the same cycle.
REQ-009 SHALL have port memData, input, 32 bits: two RGB555 pixels, left pixel in [15:0], right pixel in [31:16], bit 15/31 ignored.
REQ-010 SHALL have ports pixCy, pixCu, pixCv, output, 8 bits each: pixel colour to the NTSC encoder.
REQ-011 SHALL have port fetchOvr, output, 1 bit: sticky overrun flag.

Function
REQ-012 SHALL hold two line banks, each 160 x 32 bits, with one valid bit per bank, plus a dispBank pointer.
REQ-013 SHALL register pixPosX and pixPosY each cycle as prevX and prevY.
REQ-014 SHALL define the row-end event E as prevX==639 and pixPosX==0; r = prevY.
REQ-015 On E, SHALL toggle dispBank.
REQ-016 On E, SHALL compute target row t = (r+2) mod 1024.
REQ-017 If t<240, SHALL start a fetch of row t into the bank just vacated by display, and clear that bank's valid bit at start.
REQ-018 If t>=240, SHALL issue no memory traffic and SHALL clear the vacated bank's valid bit.
REQ-019 The fetch FSM SHALL have states IDLE, REQ and ABORT.
REQ-020 Fetch FSM transitions: IDLE->REQ on start; REQ stays until memAck; on memAck, write memData to word index w, then w+1.
REQ-021 After word 159 is acknowledged, the FSM SHALL set the bank valid bit and go to IDLE.
REQ-022 memAddr SHALL equal baseAddr + t*160 + w, computed in 24-bit modulo arithmetic; memReq SHALL be high only in REQ and ABORT.
REQ-023 memReq and memAddr SHALL remain stable until memAck.
REQ-024 If E occurs while the FSM is not IDLE: set fetchOvr=1; go to ABORT, which finishes the outstanding transaction, discards its data, then starts the new fetch.
REQ-025 On an aborted fetch, the affected bank SHALL stay invalid.
REQ-026 Read path: column c = pixPosX[9:1], word c[8:1], half c[0] (0 = [15:0]).
REQ-027 Pixel expansion: expand each 5-bit channel to 8 bits as (x<<3)|(x>>2), giving R, G and B.
REQ-028 Cy SHALL be (77R+150G+29B)>>8.
REQ-029 Cu SHALL be ((-43R-85G+128B)>>>8)+128, using arithmetic floor shift, clamped to 0..255.
REQ-030 Cv SHALL be ((128R-107G-21B)>>>8)+128, using arithmetic floor shift, clamped to 0..255.
REQ-031 Black SHALL be Cy=0, Cu=128, Cv=128, output when the display bank is invalid, pixPosY>=240, or pixPosX>=640.
REQ-032 Latency: pix outputs SHALL reflect a new (pixPosX, pixPosY) exactly 2 cycles later (bank read register, then convert register).
REQ-033 A bank write and a display read of the same bank in the same cycle cannot occur by construction; if it does, write data SHALL take priority and the read SHALL return the old word.

Reset
REQ-034 While reset is 0, SHALL force memReq=0, memAddr=0, FSM=IDLE, w=0, dispBank=0, both valid bits=0, fetchOvr=0, prevX=prevY=0.
REQ-035 While reset is 0, SHALL force pixCy=0, pixCu=128, pixCv=128; bank contents are not reset.
REQ-036 Reset asserted mid-fetch SHALL drop memReq immediately; after release, no fetch SHALL occur until the next E.
REQ-037 fetchOvr SHALL clear only on reset.

Verification
REQ-038 Row fetch: baseAddr=0x001000, E with r=5 -> 160 requests at addresses 0x001000+7*160 = 0x001460..0x0014FF, ack 1 cycle after req; bank becomes valid after word 159.
REQ-039 Colour: row filled with 0x7FFF7C00, pixPosX=0 then 2 -> after 2 cycles, red Cy/Cu/Cv=76/85/255 at X=0 and white 255/128/128 at X=2.
REQ-040 Wrap: E with r=1022 -> fetch of row 0; E with r=1023 -> fetch of row 1; E with r=238 -> no memReq and black output on the next line.
REQ-041 Overrun: memAck withheld so only 100 words complete, then E -> fetchOvr=1; outstanding transaction completes; new fetch starts at word 0 of the new target row.
REQ-042 Reset: reset=0 asserted during REQ at word 50 -> memReq=0 the same cycle and pixCy/Cu/Cv=0/128/128; no requests until E after release.
REQ-043 Invalid bank: after reset, pixPosY=3, pixPosX=100 -> black output.

Source files
------------

// File: rtl/ntsc_pix_fetch.sv
// Double-buffered line fetcher for the NTSC encoder: prefetches framebuffer rows into
// two line banks and converts the displayed RGB555 pixels to Y/Cb/Cr with 2-cycle latency.
module ntsc_pix_fetch (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  pixPosX,
  input  logic [9:0]  pixPosY,
  input  logic [23:0] baseAddr,
  output logic        memReq,
  output logic [23:0] memAddr,
  input  logic        memAck,
  input  logic [31:0] memData,
  output logic [7:0]  pixCy,
  output logic [7:0]  pixCu,
  output logic [7:0]  pixCv,
  output logic        fetchOvr
);

  typedef enum logic [1:0] {IDLE, REQ, ABORT} fetchState_t;

  fetchState_t state, stateNext;
  logic [9:0]  prevX, prevY;
  logic        rowEnd, tgtFetch, overrun;
  logic [9:0]  tgtRow;
  logic        dispBank;
  logic [1:0]  bankVld;
  logic [7:0]  wordIdx;
  logic [23:0] rowAddr, startAddr;
  logic        fetchBank;
  logic [9:0]  pendRow;
  logic        pendFetch, pendBank;
  logic        startFetch, startBank, bankWe, setVld;
  logic [9:0]  startRow;

  logic [31:0] bank0 [160];
  logic [31:0] bank1 [160];

  assign rowEnd    = (prevX == 10'd639) && (pixPosX == 10'd0);
  assign tgtRow    = prevY + 10'd2;
  assign tgtFetch  = (tgtRow < 10'd240);
  assign overrun   = rowEnd && (state != IDLE);
  assign startAddr = baseAddr + ({14'd0, startRow} * 24'd160);
  assign memReq    = (state == REQ) || (state == ABORT);
  assign memAddr   = memReq ? (rowAddr + {16'd0, wordIdx}) : 24'd0;

  always_comb begin
    stateNext  = state;
    startFetch = 1'b0;
    startRow   = tgtRow;
    startBank  = dispBank;
    bankWe     = 1'b0;
    setVld     = 1'b0;
    case (state)
      IDLE: begin
        if (rowEnd && tgtFetch) begin
          startFetch = 1'b1;
          stateNext  = REQ;
        end
      end
      REQ: begin
        if (rowEnd) begin
          // A new row arrived before this one finished: an acked word is simply dropped.
          if (memAck) begin
            startFetch = tgtFetch;
            stateNext  = tgtFetch ? REQ : IDLE;
          end else begin
            stateNext = ABORT;
          end
        end else if (memAck) begin
          bankWe = 1'b1;
          if (wordIdx == 8'd159) begin
            setVld    = 1'b1;
            stateNext = IDLE;
          end
        end
      end
      ABORT: begin
        if (memAck) begin
          if (!rowEnd) begin
            startRow  = pendRow;
            startBank = pendBank;
          end
          startFetch = rowEnd ? tgtFetch : pendFetch;
          stateNext  = startFetch ? REQ : IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      prevX     <= 10'd0;
      prevY     <= 10'd0;
      dispBank  <= 1'b0;
      bankVld   <= 2'b00;
      fetchOvr  <= 1'b0;
      wordIdx   <= 8'd0;
      rowAddr   <= 24'd0;
      fetchBank <= 1'b0;
      pendRow   <= 10'd0;
      pendFetch <= 1'b0;
      pendBank  <= 1'b0;
    end else begin
      state <= stateNext;
      prevX <= pixPosX;
      prevY <= pixPosY;
      if (rowEnd) begin
        dispBank          <= ~dispBank;
        bankVld[dispBank] <= 1'b0;
        pendRow           <= tgtRow;
        pendFetch         <= tgtFetch;
        pendBank          <= dispBank;
      end
      if (overrun)
        fetchOvr <= 1'b1;
      if (startFetch) begin
        wordIdx   <= 8'd0;
        rowAddr   <= startAddr;
        fetchBank <= startBank;
      end else if (bankWe) begin
        wordIdx <= wordIdx + 8'd1;
      end
      if (setVld)
        bankVld[fetchBank] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (bankWe) begin
      if (fetchBank)
        bank1[wordIdx] <= memData;
      else
        bank0[wordIdx] <= memData;
    end
  end

  function automatic logic [7:0] expand5(input logic [4:0] x);
    return {x, x[4:2]};
  endfunction

  function automatic logic [7:0] satU8(input logic signed [17:0] v);
    if (v < 0)
      return 8'd0;
    else if (v > 18'sd255)
      return 8'd255;
    else
      return v[7:0];
  endfunction

  logic [7:0]  rdIdx;
  logic        rdBlack;
  logic [15:0] pix_p0;
  logic        vld_p0;

  assign rdIdx   = (pixPosX[9:2] > 8'd159) ? 8'd0 : pixPosX[9:2];
  assign rdBlack = !bankVld[dispBank] || (pixPosY >= 10'd240) || (pixPosX >= 10'd640);

  // Stage p0: bank read register, half-word select
  always_ff @(posedge clock) begin
    if (pixPosX[1])
      pix_p0 <= dispBank ? bank1[rdIdx][31:16] : bank0[rdIdx][31:16];
    else
      pix_p0 <= dispBank ? bank1[rdIdx][15:0] : bank0[rdIdx][15:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      vld_p0 <= 1'b0;
    else
      vld_p0 <= !rdBlack;
  end

  logic unusedPixBit;
  assign unusedPixBit = pix_p0[15];

  logic signed [17:0] rS, gS, bS, cySum, cuSum, cvSum;
  always_comb begin
    rS    = $signed({10'd0, expand5(pix_p0[14:10])});
    gS    = $signed({10'd0, expand5(pix_p0[9:5])});
    bS    = $signed({10'd0, expand5(pix_p0[4:0])});
    cySum = (18'sd77 * rS) + (18'sd150 * gS) + (18'sd29 * bS);
    cuSum = (-18'sd43 * rS) - (18'sd85 * gS) + (18'sd128 * bS);
    cvSum = (18'sd128 * rS) - (18'sd107 * gS) - (18'sd21 * bS);
  end

  // Stage p1: colour conversion register driving the encoder
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pixCy <= 8'd0;
      pixCu <= 8'd128;
      pixCv <= 8'd128;
    end else if (vld_p0) begin
      pixCy <= satU8(cySum >>> 8);
      pixCu <= satU8((cuSum >>> 8) + 18'sd128);
      pixCv <= satU8((cvSum >>> 8) + 18'sd128);
    end else begin
      pixCy <= 8'd0;
      pixCu <= 8'd128;
      pixCv <= 8'd128;
    end
  end

endmodule

// File: tb/tb_ntsc_pix_fetch.sv
// Directed bench for ntsc_pix_fetch: row fetch, colour conversion, row wrap, overrun and reset.
module tb_ntsc_pix_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  pixPosX, pixPosY;
  logic [23:0] baseAddr;
  logic        memReq;
  logic [23:0] memAddr;
  logic        memAck;
  logic [31:0] memData;
  logic [7:0]  pixCy, pixCu, pixCv;
  logic        fetchOvr;

  int total = 0;
  int bad = 0;
  int ackCount = 0;
  int reqCycles = 0;
  int ackLimit = 0;
  logic        armed;
  logic [23:0] addrLog [0:4095];

  ntsc_pix_fetch dut (
    .clock(clock), .reset(reset), .pixPosX(pixPosX), .pixPosY(pixPosY),
    .baseAddr(baseAddr), .memReq(memReq), .memAddr(memAddr), .memAck(memAck),
    .memData(memData), .pixCy(pixCy), .pixCu(pixCu), .pixCv(pixCv), .fetchOvr(fetchOvr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Memory model: one request cycle, then a one-cycle ack; logs every acked address.
  initial begin
    memAck = 1'b0;
    armed  = 1'b0;
    memData = 32'h7FFF7C00;
    forever begin
      @(negedge clock);
      if (memReq) reqCycles++;
      if (memAck) begin
        memAck = 1'b0;
        armed  = memReq;
      end else if (memReq && armed && ackCount < ackLimit) begin
        memAck = 1'b1;
        addrLog[ackCount] = memAddr;
        ackCount++;
      end else begin
        armed = memReq;
      end
    end
  end

  task automatic endRow(input int r);
    @(negedge clock);
    pixPosX = 10'd639;
    pixPosY = 10'(r);
    @(negedge clock);
    pixPosX = 10'd0;
    pixPosY = 10'((r + 1) % 1024);
    @(negedge clock);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (memReq && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk("fetchEnd", {31'd0, memReq}, 32'd0);
  endtask

  task automatic waitAcks(input int target);
    int n = 0;
    while (ackCount < target && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk("ackReach", ackCount, target);
  endtask

  task automatic pixAt(input string tag, input int x, input int y,
                       input int cy, input int cu, input int cv);
    @(negedge clock);
    pixPosX = 10'(x);
    pixPosY = 10'(y);
    @(negedge clock);
    @(negedge clock);
    chk({tag, "Cy"}, {24'd0, pixCy}, cy);
    chk({tag, "Cu"}, {24'd0, pixCu}, cu);
    chk({tag, "Cv"}, {24'd0, pixCv}, cv);
  endtask

  initial begin
    int base;
    int rb;
    int errs;
    pixPosX  = 10'd0;
    pixPosY  = 10'd0;
    baseAddr = 24'h001000;
    repeat (3) @(negedge clock);
    chk("rstReq", {31'd0, memReq}, 0);
    chk("rstAddr", {8'd0, memAddr}, 0);
    chk("rstCy", {24'd0, pixCy}, 0);
    chk("rstCu", {24'd0, pixCu}, 128);
    chk("rstCv", {24'd0, pixCv}, 128);
    chk("rstOvr", {31'd0, fetchOvr}, 0);
    reset = 1'b1;
    ackLimit = 100000;

    pixAt("invBank", 100, 3, 0, 128, 128);

    base = ackCount;
    endRow(5);
    waitIdle();
    chk("rowCnt", ackCount - base, 160);
    chk("rowFirst", {8'd0, addrLog[base]}, 32'h001460);
    chk("rowLast", {8'd0, addrLog[base + 159]}, 32'h0014FF);
    errs = 0;
    for (int i = 0; i < 160; i++)
      if (addrLog[base + i] != 24'h001460 + 24'(i)) errs++;
    chk("rowSeq", errs, 0);
    pixAt("otherBank", 0, 6, 0, 128, 128);

    endRow(6);
    waitIdle();
    pixAt("redX0", 0, 7, 76, 85, 255);
    pixAt("redX1", 1, 7, 76, 85, 255);
    pixAt("whiteX2", 2, 7, 255, 128, 128);
    pixAt("blkX640", 640, 7, 0, 128, 128);
    pixAt("blkY240", 0, 240, 0, 128, 128);

    base = ackCount;
    endRow(1022);
    waitIdle();
    chk("wrap0Cnt", ackCount - base, 160);
    chk("wrap0Addr", {8'd0, addrLog[base]}, 32'h001000);
    base = ackCount;
    endRow(1023);
    waitIdle();
    chk("wrap1Addr", {8'd0, addrLog[base]}, 32'h0010A0);
    rb = reqCycles;
    endRow(238);
    repeat (20) @(negedge clock);
    chk("row240NoReq", reqCycles - rb, 0);
    pixAt("row239", 0, 239, 76, 85, 255);
    endRow(239);
    pixAt("clearedBank", 0, 100, 0, 128, 128);

    base = ackCount;
    ackLimit = base + 100;
    endRow(10);
    waitAcks(base + 100);
    repeat (3) @(negedge clock);
    chk("ovrBefore", {31'd0, fetchOvr}, 0);
    endRow(20);
    chk("ovrSet", {31'd0, fetchOvr}, 1);
    chk("abortReq", {31'd0, memReq}, 1);
    chk("abortAddr", {8'd0, memAddr}, 32'h0017E4);
    base = ackCount;
    ackLimit = 100000;
    waitIdle();
    chk("ovrCnt", ackCount - base, 161);
    chk("ovrOld", {8'd0, addrLog[base]}, 32'h0017E4);
    chk("ovrNew", {8'd0, addrLog[base + 1]}, 32'h001DC0);
    chk("ovrLast", {8'd0, addrLog[base + 160]}, 32'h001E5F);
    chk("ovrSticky", {31'd0, fetchOvr}, 1);
    pixAt("abortedBank", 0, 21, 0, 128, 128);

    base = ackCount;
    ackLimit = base + 50;
    endRow(30);
    waitAcks(base + 50);
    @(negedge clock);
    chk("w50Addr", {8'd0, memAddr}, 32'h002432);
    #2 reset = 1'b0;
    #1;
    chk("midRstReq", {31'd0, memReq}, 0);
    chk("midRstAddr", {8'd0, memAddr}, 0);
    chk("midRstCy", {24'd0, pixCy}, 0);
    chk("midRstCu", {24'd0, pixCu}, 128);
    chk("midRstCv", {24'd0, pixCv}, 128);
    chk("midRstOvr", {31'd0, fetchOvr}, 0);
    @(negedge clock);
    reset = 1'b1;
    ackLimit = 100000;
    rb = reqCycles;
    repeat (20) @(negedge clock);
    chk("postRstNoReq", reqCycles - rb, 0);
    base = ackCount;
    endRow(40);
    chk("postRstReq", {31'd0, memReq}, 1);
    waitIdle();
    chk("postRstAddr", {8'd0, addrLog[base]}, 32'h002A40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
